// File: rtl/div_unit_pkg.sv
// Shared definitions for the RV32M multi-cycle divider: funct3 codes and FSM states.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package div_unit_pkg;

    // funct3 codes of the M-extension divide group
    typedef enum logic [2:0] {
        INST_DIV  = 3'b100,
        INST_DIVU = 3'b101,
        INST_REM  = 3'b110,
        INST_REMU = 3'b111
    } div_op_e;

    // One-hot controller states
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_START = 4'b0010,
        ST_CALC  = 4'b0100,
        ST_END   = 4'b1000
    } div_state_e;

    // True for the four funct3 codes this unit executes
    function automatic logic is_div_op(input logic [2:0] op);
        return (op == INST_DIV)  || (op == INST_DIVU) ||
               (op == INST_REM)  || (op == INST_REMU);
    endfunction

    // funct3[1] selects remainder, funct3[0] selects unsigned
    function automatic logic op_is_rem(input logic [1:0] op_lo);
        return op_lo[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op_lo);
        return ~op_lo[0];
    endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), restoring shift-subtract, one quotient bit per cycle.
// Latency: ready_o pulses 34 cycles after start acceptance (2 cycles for a zero divisor).
// Backpressure: none; start_i is only honoured in IDLE, the issuer waits for ready_o before the next start.
//
// Ports:
//   clk, rst            clock and synchronous active-low reset
//   start_i, op_i       request pulse and funct3 (1xx accepted, anything else ignored)
//   dividend_i          rs1 value
//   divisor_i           rs2 value
//   reg_waddr_i         destination register, echoed on reg_waddr_o with the result
//   result_o, ready_o   quotient/remainder and its one-cycle completion strobe
//   busy_o              high from the cycle after acceptance until ready_o drops
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic [4:0]      reg_waddr_i,
    output logic [XLEN-1:0] result_o,
    output logic            ready_o,
    output logic            busy_o,
    output logic [4:0]      reg_waddr_o
);

    // Conditional two's-complement negate, used both for operand
    // magnitudes and for restoring the sign of the result.
    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
        return n ? (-v) : v;
    endfunction

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    div_state_e      state_q, state_d;
    logic [1:0]      op_q, op_d;            // funct3[1:0]; funct3[2] is always 1 once accepted
    logic [XLEN-1:0] dvd_q, dvd_d;          // dividend, shifted left as bits are consumed
    logic [XLEN-1:0] dsr_q, dsr_d;          // divisor (magnitude after START)
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            inv_quo_q, inv_quo_d;
    logic            inv_rem_q, inv_rem_d;
    logic [4:0]      waddr_q, waddr_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic [4:0]      waddr_out_q, waddr_out_d;

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    // The partial remainder is kept XLEN bits wide, but the shifted trial
    // value needs one extra bit: for unsigned divisors >= 2^(XLEN-1) the
    // shifted remainder can exceed XLEN bits before the subtract.
    logic [XLEN:0]   trial;
    logic            trial_ge;
    logic [XLEN-1:0] trial_diff;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;

    always_comb begin
        trial      = {rem_q, dvd_q[XLEN-1]};
        trial_ge   = (trial >= {1'b0, dsr_q});
        // When trial_ge holds the true difference is below the divisor, so
        // the low XLEN bits of the subtraction are exact.
        trial_diff = trial[XLEN-1:0] - dsr_q;
        rem_next   = trial_ge ? trial_diff : trial[XLEN-1:0];
        quo_next   = {quo_q[XLEN-2:0], trial_ge};
    end

    // ------------------------------------------------------------------
    // State register (synchronous active-low reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            inv_quo_q   <= 1'b0;
            inv_rem_q   <= 1'b0;
            waddr_q     <= '0;
            result_q    <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            waddr_out_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            inv_quo_q   <= inv_quo_d;
            inv_rem_q   <= inv_rem_d;
            waddr_q     <= waddr_d;
            result_q    <= result_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            waddr_out_q <= waddr_out_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_i && is_div_op(op_i)) state_d = ST_START;
            ST_START: state_d = (dsr_q == '0) ? ST_END : ST_CALC;
            ST_CALC:  if (cnt_q == LAST_CNT) state_d = ST_END;
            ST_END:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath / output logic. Outputs are registered, so the values seen
    // in END are loaded on the edge that enters END.
    // ------------------------------------------------------------------
    always_comb begin
        op_d        = op_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        inv_quo_d   = inv_quo_q;
        inv_rem_d   = inv_rem_q;
        waddr_d     = waddr_q;
        result_d    = result_q;
        ready_d     = 1'b0;
        busy_d      = busy_q;
        waddr_out_d = waddr_out_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i && is_div_op(op_i)) begin
                    op_d    = op_i[1:0];
                    dvd_d   = dividend_i;
                    dsr_d   = divisor_i;
                    waddr_d = reg_waddr_i;
                    busy_d  = 1'b1;
                end
            end

            ST_START: begin
                if (dsr_q == '0) begin
                    // Architectural divide-by-zero results, no iteration
                    result_d    = op_is_rem(op_q) ? dvd_q : '1;
                    ready_d     = 1'b1;
                    waddr_out_d = waddr_q;
                end else begin
                    dvd_d     = neg_if(dvd_q, op_is_signed(op_q) & dvd_q[XLEN-1]);
                    dsr_d     = neg_if(dsr_q, op_is_signed(op_q) & dsr_q[XLEN-1]);
                    inv_quo_d = op_is_signed(op_q) & (dvd_q[XLEN-1] ^ dsr_q[XLEN-1]);
                    inv_rem_d = op_is_signed(op_q) & dvd_q[XLEN-1];
                    quo_d     = '0;
                    rem_d     = '0;
                    cnt_d     = '0;
                end
            end

            ST_CALC: begin
                rem_d = rem_next;
                quo_d = quo_next;
                dvd_d = dvd_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // Final bit: publish straight from the iteration outputs.
                    // The most-negative / -1 overflow falls out naturally:
                    // magnitude 2^(XLEN-1) with inv_quo clear.
                    result_d    = op_is_rem(op_q) ? neg_if(rem_next, inv_rem_q)
                                                  : neg_if(quo_next, inv_quo_q);
                    ready_d     = 1'b1;
                    waddr_out_d = waddr_q;
                end
            end

            ST_END: begin
                busy_d = 1'b0;
            end

            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign result_o    = result_q;
    assign ready_o     = ready_q;
    assign busy_o      = busy_q;
    assign reg_waddr_o = waddr_out_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, protocol corner sequences, randomized ops vs. arithmetic model.
// Latency: expects ready_o in cycle 34 after acceptance (cycle 2 for a zero divisor).
// Backpressure: n/a.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [4:0]  reg_waddr_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic        busy_o;
    logic [4:0]  reg_waddr_o;

    int n_checks = 0;
    int n_errors = 0;

    div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .op_i       (op_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .reg_waddr_i(reg_waddr_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .reg_waddr_o(reg_waddr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  wa;
        logic [31:0] exp_r;
        string       name;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RISC-V M-extension semantics in plain arithmetic
    function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return (op[1]) ? a : 32'hFFFF_FFFF;
        case (op)
            3'b101: return a / b;
            3'b111: return a % b;
            3'b100: begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            default: begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [31:0] b);
        return (b == 32'd0) ? 2 : 34;
    endfunction

    // Issues one op, optionally re-pulses start_i (valid op, other operands)
    // in cycle inj, and also holds start_i during the END cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wa, input logic [31:0] exp_r, input int inj,
                          input string name);
        int lat;
        bit busy_ok;
        start_i     = 1'b1;
        op_i        = op;
        dividend_i  = a;
        divisor_i   = b;
        reg_waddr_i = wa;
        @(posedge clk); #1;
        start_i     = 1'b0;
        dividend_i  = $urandom;
        divisor_i   = $urandom;
        reg_waddr_i = wa ^ 5'h1F;
        lat     = 1;
        busy_ok = 1'b1;
        while (!ready_o && lat < 60) begin
            if (!busy_o) busy_ok = 1'b0;
            if (lat == inj) begin
                start_i    = 1'b1;
                op_i       = 3'b101;
                dividend_i = 32'd50;
                divisor_i  = 32'd5;
            end
            @(posedge clk); #1;
            start_i = 1'b0;
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'(ref_lat(b)));
        chk({name, " result"}, result_o, exp_r);
        chk({name, " waddr"}, {27'd0, reg_waddr_o}, {27'd0, wa});
        chk({name, " busy_during"}, {31'd0, busy_ok & busy_o}, 32'd1);
        // Start in END must be ignored; ready is a single-cycle pulse
        start_i    = 1'b1;
        op_i       = 3'b101;
        dividend_i = 32'd77;
        divisor_i  = 32'd1;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk({name, " ready_pulse"}, {30'd0, ready_o, busy_o}, 32'd0);
        chk({name, " result_hold"}, result_o, exp_r);
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{3'b101, 32'd100,        32'd7,          5'd5,  32'd14,         "divu_100_7"};
        vecs[1] = '{3'b100, 32'hFFFF_FFF9,  32'd2,          5'd1,  32'hFFFF_FFFD,  "div_m7_2"};
        vecs[2] = '{3'b110, 32'hFFFF_FFF9,  32'd2,          5'd2,  32'hFFFF_FFFF,  "rem_m7_2"};
        vecs[3] = '{3'b101, 32'd123,        32'd0,          5'd3,  32'hFFFF_FFFF,  "divu_by0"};
        vecs[4] = '{3'b110, 32'h8000_0000,  32'd0,          5'd4,  32'h8000_0000,  "rem_by0"};
        vecs[5] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd31, 32'h8000_0000,  "div_ovf"};
        vecs[6] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd30, 32'd0,          "rem_ovf"};
        vecs[7] = '{3'b111, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  5'd7,  32'd1,          "remu_big"};
        vecs[8] = '{3'b101, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  5'd8,  32'd1,          "divu_big"};
        vecs[9] = '{3'b100, 32'd7,          32'hFFFF_FFFE,  5'd9,  32'hFFFF_FFFD,  "div_7_m2"};

        rst         = 1'b0;
        start_i     = 1'b0;
        op_i        = 3'b000;
        dividend_i  = '0;
        divisor_i   = '0;
        reg_waddr_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset result", result_o, 32'd0);
        chk("reset ready", {31'd0, ready_o}, 32'd0);
        chk("reset busy", {31'd0, busy_o}, 32'd0);
        chk("reset waddr", {27'd0, reg_waddr_o}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 10; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].wa, vecs[i].exp_r, 0, vecs[i].name);

        // Second start in cycle 10 is ignored
        run_op(3'b101, 32'd1000, 32'd3, 5'd12, 32'd333, 10, "restart_ignored");

        // Illegal funct3 in IDLE never starts the unit
        begin
            bit stayed_idle;
            stayed_idle = 1'b1;
            start_i     = 1'b1;
            op_i        = 3'b000;
            dividend_i  = 32'd10;
            divisor_i   = 32'd2;
            @(posedge clk); #1;
            start_i = 1'b0;
            for (int c = 0; c < 40; c++) begin
                if (busy_o || ready_o) stayed_idle = 1'b0;
                @(posedge clk); #1;
            end
            chk("bad_op idle", {31'd0, stayed_idle}, 32'd1);
        end

        // Reset in cycle 15 of an operation discards it
        begin
            bit no_ready;
            start_i     = 1'b1;
            op_i        = 3'b101;
            dividend_i  = 32'd1000;
            divisor_i   = 32'd7;
            reg_waddr_i = 5'd9;
            @(posedge clk); #1;
            start_i = 1'b0;
            for (int c = 1; c < 15; c++) begin
                @(posedge clk); #1;
            end
            rst = 1'b0;
            @(posedge clk); #1;
            chk("midrst busy", {31'd0, busy_o}, 32'd0);
            chk("midrst ready", {31'd0, ready_o}, 32'd0);
            chk("midrst result", result_o, 32'd0);
            chk("midrst waddr", {27'd0, reg_waddr_o}, 32'd0);
            rst      = 1'b1;
            no_ready = 1'b1;
            for (int c = 0; c < 40; c++) begin
                if (ready_o || busy_o) no_ready = 1'b0;
                @(posedge clk); #1;
            end
            chk("midrst no_pulse", {31'd0, no_ready}, 32'd1);
            run_op(3'b101, 32'd9, 32'd3, 5'd6, 32'd3, 0, "after_rst");
        end

        // Randomized ops against the arithmetic model
        for (int k = 0; k < 40; k++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            logic [4:0]  wa;
            int          sel;
            op  = 3'b100 | 3'($urandom_range(0, 3));
            a   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0)      b = 32'd0;
            else if (sel == 1) b = 32'hFFFF_FFFF;
            else if (sel == 2) b = 32'($urandom_range(1, 15));
            else if (sel == 3) b = -32'($urandom_range(1, 15));
            else               b = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            wa = 5'($urandom);
            run_op(op, a, b, wa, ref_div(op, a, b), 0, $sformatf("rnd%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
